uart_rx: RTL and testbench



---
 rtl/my_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 47 ++++
 rtl/uart_rx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared register offsets and receive FSM state type for uart_rx
package my_pkg;

  localparam logic [3:0] UART_RX_DATA   = 4'h0;
  localparam logic [3:0] UART_RX_STATUS = 4'h4;
  localparam logic [3:0] UART_RX_DIV    = 4'h8;
  localparam logic [3:0] UART_RX_CTRL   = 4'hC;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO with wrap-around pointers for the UART receiver
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  // The extra pointer bit tells a full buffer apart from an empty one
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push while full is still taken
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers guard them
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - memory-mapped UART receiver (8N1, even parity with UART_RX_PARITY_EN)
module uart_rx
  import my_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int DEFAULT_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [3:0]  write_enable_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        rx_i,
  output logic        irq_o
);

  logic           rx_s1, rx_s2, rx_prev;
  uart_rx_state_t state;
  logic [15:0]    cnt, div_w, div_reg, div_next;
  logic [2:0]     bit_cnt;
  logic [7:0]     sh;
  logic           par_bad;
  logic           rx_en, irq_en;
  logic           overrun, frame_err, parity_err;
  logic           fifo_full, fifo_empty;
  logic [7:0]     fifo_head;
  logic           tick, stop_tick, push, pop, ovr_evt, frame_evt, par_evt;
  logic           bus_rd, bus_wr, w1c;
  logic [1:0]     reg_sel;
  logic [31:0]    rd_mux;
  logic           unused_bits;

  assign unused_bits = ^{data_i[31:16], addr_i[1:0]};

  assign reg_sel = addr_i[3:2];
  assign bus_rd  = enable_i & (write_enable_i == 4'b0000);
  assign bus_wr  = enable_i & (write_enable_i != 4'b0000);
  assign w1c     = bus_wr & (reg_sel == UART_RX_STATUS[3:2]) & write_enable_i[0];

  // Event decode from registered FSM state and the synchronized line
  assign tick      = (cnt == 16'd1);
  assign stop_tick = rx_en & (state == STOP) & tick;
  assign push      = stop_tick & rx_s2 & ~par_bad;
  assign frame_evt = stop_tick & ~rx_s2;
  assign pop       = bus_rd & (reg_sel == UART_RX_DATA[3:2]) & ~fifo_empty;
  assign ovr_evt   = push & fifo_full & ~pop;
`ifdef UART_RX_PARITY_EN
  assign par_evt   = rx_en & (state == PARITY) & tick & (rx_s2 != ^sh);
`else
  assign par_evt   = 1'b0;
`endif

  // Two-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receive FSM with baud counter; a count of 1 marks the sample point
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      div_w   <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      par_bad <= 1'b0;
    end else if (!rx_en) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rx_prev & ~rx_s2) begin
            div_w <= div_reg;
            cnt   <= div_reg >> 1;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rx_s2) begin
              state <= IDLE;
            end else begin
              cnt     <= div_w;
              bit_cnt <= '0;
              par_bad <= 1'b0;
              state   <= DATA;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DATA: begin
          if (tick) begin
            sh      <= {rx_s2, sh[7:1]};
            cnt     <= div_w;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            par_bad <= (rx_s2 != ^sh);
            cnt     <= div_w;
            state   <= STOP;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
`endif
        STOP: begin
          // Leave at mid stop bit so the next start edge is not missed
          if (tick) state <= IDLE;
          else      cnt   <= cnt - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Divisor write merge with lane strobes, clamped to the minimum of 2
  always_comb begin
    div_next = div_reg;
    if (write_enable_i[0]) div_next[7:0]  = data_i[7:0];
    if (write_enable_i[1]) div_next[15:8] = data_i[15:8];
    if (div_next < 16'd2)  div_next       = 16'd2;
  end

  // Read data mux; an empty FIFO reads as zero
  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      2'd0:    rd_mux = {24'd0, fifo_empty ? 8'd0 : fifo_head};
      2'd1:    rd_mux = {27'd0, parity_err, frame_err, overrun, fifo_full, ~fifo_empty};
      2'd2:    rd_mux = {16'd0, div_reg};
      default: rd_mux = {30'd0, irq_en, rx_en};
    endcase
  end

  // Register file, sticky flags (set beats W1C), read data and interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg   <= 16'(DEFAULT_DIV);
      rx_en     <= 1'b0;
      irq_en    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      data_o    <= '0;
      irq_o     <= 1'b0;
    end else begin
      if (bus_wr && reg_sel == UART_RX_DIV[3:2] && (write_enable_i[1:0] != 2'b00))
        div_reg <= div_next;
      if (bus_wr && reg_sel == UART_RX_CTRL[3:2] && write_enable_i[0])
        {irq_en, rx_en} <= data_i[1:0];
      overrun   <= ovr_evt   | (overrun   & ~(w1c & data_i[2]));
      frame_err <= frame_evt | (frame_err & ~(w1c & data_i[3]));
      if (bus_rd) data_o <= rd_mux;
      irq_o <= irq_en & (~fifo_empty | overrun | frame_err | parity_err);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error flag, present only in parity builds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err <= 1'b0;
    else        parity_err <= par_evt | (parity_err & ~(w1c & data_i[4]));
  end
`else
  assign parity_err = par_evt;
`endif

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (sh),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
module tb_uart_rx;

  localparam int BITC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable_i = 1'b0;
  logic [3:0]  write_enable_i = 4'd0;
  logic [3:0]  addr_i = 4'd0;
  logic [31:0] data_i = 32'd0;
  logic [31:0] data_o;
  logic        rx_i = 1'b1;
  logic        irq_o;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_pend = 1'b0;

  uart_rx #(.FIFO_DEPTH(4), .DEFAULT_DIV(434)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable_i       (enable_i),
    .write_enable_i (write_enable_i),
    .addr_i         (addr_i),
    .data_i         (data_i),
    .data_o         (data_o),
    .rx_i           (rx_i),
    .irq_o          (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_pend <= enable_i && (write_enable_i == 4'd0);

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read: got 0x%0h expected no read", data_o);
      end else begin
        check(name_q.pop_front(), data_o, exp_q.pop_front());
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [3:0] we, input logic [31:0] d);
    @(posedge clk); #1;
    enable_i = 1'b1; write_enable_i = we; addr_i = a; data_i = d;
    @(posedge clk); #1;
    enable_i = 1'b0; write_enable_i = 4'd0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk); #1;
    enable_i = 1'b1; write_enable_i = 4'd0; addr_i = a;
    @(posedge clk); #1;
    enable_i = 1'b0;
  endtask

  task automatic hold_bit(input logic v);
    rx_i = v;
    repeat (BITC) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input logic has_par, input logic par);
    @(posedge clk); #1;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    if (has_par) hold_bit(par);
    hold_bit(stop);
    rx_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("reset_data_o", data_o, 32'd0);
    check("reset_irq", {31'd0, irq_o}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    bus_read(4'h0, 32'd0, "rst_data");
    bus_read(4'h4, 32'd0, "rst_status");
    bus_read(4'h8, 32'd434, "rst_div");
    bus_read(4'hC, 32'd0, "rst_ctrl");
    check("rst_irq", {31'd0, irq_o}, 32'd0);

    bus_write(4'h8, 4'b0011, 32'd1);
    bus_read(4'h8, 32'd2, "div_clamp");
    bus_write(4'h8, 4'b0011, 32'd16);
    bus_read(4'h8, 32'd16, "div_16");
    bus_write(4'hC, 4'b0001, 32'h3);
    bus_read(4'hC, 32'h3, "ctrl_3");

    send_byte(8'hA5, 1'b1, 1'b0, 1'b0);
    bus_read(4'h4, 32'h1, "a5_status");
    check("a5_irq_high", {31'd0, irq_o}, 32'd1);
    bus_read(4'h0, 32'hA5, "a5_data");
    check("irq_lag", {31'd0, irq_o}, 32'd1);
    @(posedge clk); #1;
    check("irq_fall", {31'd0, irq_o}, 32'd0);
    bus_read(4'h4, 32'h0, "a5_status_after");

    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0, 1'b0);
    bus_read(4'h4, 32'h7, "ovr_status");
    for (int i = 1; i <= 4; i++) bus_read(4'h0, 32'(i), "ovr_data");
    bus_read(4'h0, 32'h0, "ovr_data_empty");
    bus_read(4'h4, 32'h4, "ovr_flag_kept");
    bus_write(4'h4, 4'b0001, 32'h4);
    bus_read(4'h4, 32'h0, "ovr_cleared");

    send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
    bus_read(4'h4, 32'h8, "frame_status");
    bus_read(4'h0, 32'h0, "frame_no_data");
    bus_write(4'h4, 4'b0001, 32'h8);
    bus_read(4'h4, 32'h0, "frame_cleared");

    @(posedge clk); #1;
    rx_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_i = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    bus_read(4'h4, 32'h0, "glitch_status");
    send_byte(8'h5A, 1'b1, 1'b0, 1'b0);
    bus_read(4'h0, 32'h5A, "post_glitch_data");

`ifdef UART_RX_PARITY_EN
    send_byte(8'h07, 1'b1, 1'b1, 1'b0);
    bus_read(4'h4, 32'h10, "par_bad_status");
    send_byte(8'h07, 1'b1, 1'b1, 1'b1);
    bus_read(4'h4, 32'h11, "par_good_status");
    bus_read(4'h0, 32'h07, "par_good_data");
    bus_write(4'h4, 4'b0001, 32'h10);
    bus_read(4'h4, 32'h0, "par_cleared");
`else
    bus_write(4'h4, 4'b0001, 32'h10);
    bus_read(4'h4, 32'h0, "nopar_bit4");
`endif

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
